// File: rtl/ofs_plat_prim_almfull_pipe_pkg.sv
// Shared sizing helpers for the almost-full absorption pipeline: the FIFO depth
// and threshold are derived from the forward+reverse round trip.
package ofs_plat_prim_almfull_pipe_pkg;

  // Worst case in flight once almost-full is asserted: the forward stages, the
  // reverse stages, upstream reaction slack, the registered compare and margin.
  function automatic int calc_fifo_depth(input int n_reg_stages, input int upstream_slack);
    return 1 << $clog2(2 * n_reg_stages + upstream_slack + 4);
  endfunction

  function automatic int calc_almfull_thresh(input int n_reg_stages, input int upstream_slack);
    return calc_fifo_depth(n_reg_stages, upstream_slack) - (2 * n_reg_stages + upstream_slack + 2);
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int calc_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_almfull_pipe_fifo.sv
// Single-channel absorption FIFO: registered (non fall-through) output, occupancy
// count, and a sticky overflow flag for pushes that arrive while full.
module ofs_plat_prim_almfull_fifo
  import ofs_plat_prim_almfull_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 8,
  parameter bit OVERFLOW_ASSERT_EN = 1'b1,
  localparam int CNT_W = calc_count_width(DEPTH)
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  overflow
);

  localparam int PTR_W = CNT_W - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is always a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (wr_en && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (OVERFLOW_ASSERT_EN && !reset) begin
      assert (!(wr_en && !do_push))
        else $error("ofs_plat_prim_almfull_fifo: push while full, beat dropped");
    end
  end

endmodule

// File: rtl/ofs_plat_prim_almfull_pipe.sv
// Multi-channel retiming pipeline that absorbs late almost-full: forward stages feed a
// per-channel FIFO whose occupancy is sent back through matching reverse stages.
module ofs_plat_prim_almfull_pipe
  import ofs_plat_prim_almfull_pipe_pkg::*;
#(
  parameter int N_CHANNELS = 2,
  parameter int DATA_WIDTH = 64,
  parameter int N_REG_STAGES = 2,
  parameter int UPSTREAM_SLACK = 0,
  parameter bit OVERFLOW_ASSERT_EN = 1'b1
)(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_CHANNELS-1:0]                in_valid,
  input  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] in_data,
  output logic [N_CHANNELS-1:0]                in_almfull,
  output logic [N_CHANNELS-1:0]                out_valid,
  output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] out_data,
  input  logic [N_CHANNELS-1:0]                out_almfull,
  output logic [N_CHANNELS-1:0]                overflow
);

  localparam int FIFO_DEPTH     = calc_fifo_depth(N_REG_STAGES, UPSTREAM_SLACK);
  localparam int ALMFULL_THRESH = calc_almfull_thresh(N_REG_STAGES, UPSTREAM_SLACK);
  localparam int CNT_W          = calc_count_width(FIFO_DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } t_stage;

  for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
    t_stage           stage_in;
    t_stage           stage_out;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;

    assign stage_in = '{valid: in_valid[ch], data: in_data[ch]};

    if (N_REG_STAGES == 0) begin : g_nostage
      assign stage_out = stage_in;
    end else begin : g_stage
      (* altera_attribute = "-name PRESERVE_REGISTER ON; -name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
      t_stage stage_q [N_REG_STAGES];

      // Only the valid bits are reset; payload just follows along.
      always_ff @(posedge clk) begin
        stage_q[0].data <= stage_in.data;
        for (int s = 1; s < N_REG_STAGES; s++) begin
          stage_q[s].data <= stage_q[s-1].data;
        end
        if (reset) begin
          for (int s = 0; s < N_REG_STAGES; s++) begin
            stage_q[s].valid <= 1'b0;
          end
        end else begin
          stage_q[0].valid <= stage_in.valid;
          for (int s = 1; s < N_REG_STAGES; s++) begin
            stage_q[s].valid <= stage_q[s-1].valid;
          end
        end
      end

      assign stage_out = stage_q[N_REG_STAGES-1];
    end

    ofs_plat_prim_almfull_fifo #(
      .DATA_WIDTH         (DATA_WIDTH),
      .DEPTH              (FIFO_DEPTH),
      .OVERFLOW_ASSERT_EN (OVERFLOW_ASSERT_EN)
    ) fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (stage_out.valid),
      .wr_data  (stage_out.data),
      .rd_en    (out_valid[ch]),
      .rd_data  (out_data[ch]),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .overflow (overflow[ch])
    );

    // Downstream takes whatever is presented, so its almost-full gates valid directly.
    assign out_valid[ch] = !fifo_empty && !out_almfull[ch];

    // Bit 0 is the registered threshold compare; the rest mirror the forward stages.
    // Everything resets to 1 so upstream stays throttled until real occupancy arrives.
    (* altera_attribute = "-name PRESERVE_REGISTER ON; -name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
    logic [N_REG_STAGES:0] af_pipe;

    always_ff @(posedge clk) begin
      if (reset) begin
        af_pipe <= '1;
      end else begin
        af_pipe[0] <= (fifo_count >= CNT_W'(ALMFULL_THRESH));
        for (int s = 1; s <= N_REG_STAGES; s++) begin
          af_pipe[s] <= af_pipe[s-1];
        end
      end
    end

    assign in_almfull[ch] = af_pipe[N_REG_STAGES];
  end

endmodule

// File: tb/tb_ofs_plat_prim_almfull_pipe.sv
// Directed bench for ofs_plat_prim_almfull_pipe (2 channels, 2 stages, depth 8, threshold 2)
// with a per-channel scoreboard of expected payloads checked as beats leave the DUT.
module tb_ofs_plat_prim_almfull_pipe;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       in_valid;
  logic [1:0][63:0] in_data;
  logic [1:0]       in_almfull;
  logic [1:0]       out_valid;
  logic [1:0][63:0] out_data;
  logic [1:0]       out_almfull;
  logic [1:0]       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sent;
  logic stopped;
  int ch1_run, ch0_stray, ch1_af, ch0_af_low;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  always #5 clk = ~clk;

  ofs_plat_prim_almfull_pipe #(
    .N_CHANNELS         (2),
    .DATA_WIDTH         (64),
    .N_REG_STAGES       (2),
    .UPSTREAM_SLACK     (0),
    .OVERFLOW_ASSERT_EN (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_almfull  (in_almfull),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_almfull (out_almfull),
    .overflow    (overflow)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [1:0] keep, input logic [1:0] oaf);
    in_valid    = v;
    in_data[0]  = d0;
    in_data[1]  = d1;
    out_almfull = oaf;
    if (v[0] && keep[0]) exp_q0.push_back(d0);
    if (v[1] && keep[1]) exp_q1.push_back(d1);
  endtask

  task automatic step(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                      input logic [1:0] keep, input logic [1:0] oaf);
    next_cycle();
    applyStimulus(v, d0, d1, keep, oaf);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] oaf);
    repeat (n) step(2'b00, 64'h0, 64'h0, 2'b00, oaf);
  endtask

  // Every emitted beat must be the oldest outstanding expected payload of its channel.
  always @(negedge clk) begin
    if (out_valid[0] === 1'b1) begin
      total++;
      assert (exp_q0.size() != 0) else begin
        bad++;
        $error("[TB] FAIL ch0 stray beat: observed data=%0h expected no beat (cycle %0d)", out_data[0], cyc);
      end
      if (exp_q0.size() != 0) checkOutput("ch0 data", out_data[0], exp_q0.pop_front());
    end
    if (out_valid[1] === 1'b1) begin
      total++;
      assert (exp_q1.size() != 0) else begin
        bad++;
        $error("[TB] FAIL ch1 stray beat: observed data=%0h expected no beat (cycle %0d)", out_data[1], cyc);
      end
      if (exp_q1.size() != 0) checkOutput("ch1 data", out_data[1], exp_q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 2'b00;
    in_data     = '0;
    out_almfull = 2'b00;
    repeat (3) next_cycle();
    #1;
    checkOutput("reset in_almfull", 64'(in_almfull), 64'h3);
    checkOutput("reset out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset overflow", 64'(overflow), 64'h0);

    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle(1, 2'b00);
      checkOutput("almfull after reset", 64'(in_almfull), (k < 3) ? 64'h3 : 64'h0);
    end

    $display("[TB] single beat latency");
    for (int k = 0; k < 7; k++) begin
      if (k == 0) step(2'b01, 64'hA5, 64'h0, 2'b01, 2'b00);
      else idle(1, 2'b00);
      checkOutput("single out_valid", 64'(out_valid), (k == 3) ? 64'h1 : 64'h0);
      checkOutput("single in_almfull", 64'(in_almfull), 64'h0);
    end

    $display("[TB] stall fill honouring in_almfull");
    sent = 0;
    stopped = 1'b0;
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      if (in_almfull[0]) stopped = 1'b1;
      if (!stopped) begin
        applyStimulus(2'b01, 64'(sent), 64'h0, 2'b01, 2'b01);
        sent++;
      end else begin
        applyStimulus(2'b00, 64'h0, 64'h0, 2'b00, 2'b01);
      end
      #1;
    end
    checkOutput("beats before almfull", 64'(sent), 64'd7);
    checkOutput("fill overflow", 64'(overflow), 64'h0);
    step(2'b01, 64'd7, 64'h0, 2'b01, 2'b01);
    idle(4, 2'b01);
    checkOutput("full overflow", 64'(overflow), 64'h0);
    checkOutput("full in_almfull", 64'(in_almfull), 64'h1);
    checkOutput("stalled out_valid", 64'(out_valid), 64'h0);

    $display("[TB] forced overflow");
    for (int k = 0; k < 6; k++) begin
      if (k == 0) step(2'b01, 64'hDEAD, 64'h0, 2'b00, 2'b01);
      else idle(1, 2'b01);
      checkOutput("overflow rise", 64'(overflow), (k >= 3) ? 64'h1 : 64'h0);
    end

    $display("[TB] drain after stall");
    for (int k = 0; k < 11; k++) begin
      idle(1, 2'b00);
      checkOutput("drain out_valid", 64'(out_valid), (k < 8) ? 64'h1 : 64'h0);
      if (k == 9)  checkOutput("drain almfull held", 64'(in_almfull), 64'h1);
      if (k == 10) checkOutput("drain almfull clear", 64'(in_almfull), 64'h0);
    end
    checkOutput("overflow sticky", 64'(overflow), 64'h1);
    checkOutput("ch0 queue drained", 64'(exp_q0.size()), 64'h0);

    $display("[TB] channel independence");
    for (int i = 0; i < 8; i++) step(2'b01, 64'(100 + i), 64'h0, 2'b01, 2'b01);
    idle(3, 2'b01);
    ch1_run = 0;
    ch0_stray = 0;
    ch1_af = 0;
    ch0_af_low = 0;
    for (int k = 0; k < 104; k++) begin
      if (k < 100) step(2'b10, 64'h0, {$urandom, $urandom}, 2'b10, 2'b01);
      else idle(1, 2'b01);
      if (k >= 3 && k <= 102 && out_valid[1]) ch1_run++;
      if (out_valid[0]) ch0_stray++;
      if (in_almfull[1]) ch1_af++;
      if (!in_almfull[0]) ch0_af_low++;
      if (k == 103) checkOutput("ch1 stream end", 64'(out_valid[1]), 64'h0);
    end
    checkOutput("ch1 continuous beats", 64'(ch1_run), 64'd100);
    checkOutput("ch0 stalled beats", 64'(ch0_stray), 64'd0);
    checkOutput("ch1 almfull cycles", 64'(ch1_af), 64'd0);
    checkOutput("ch0 almfull low cycles", 64'(ch0_af_low), 64'd0);
    checkOutput("ch1 queue drained", 64'(exp_q1.size()), 64'h0);
    idle(10, 2'b00);
    checkOutput("ch0 refill drained", 64'(exp_q0.size()), 64'h0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++) step(2'b01, 64'(16'h500 + i), 64'h0, 2'b00, 2'b11);
    idle(3, 2'b11);
    step(2'b01, 64'h600, 64'h0, 2'b00, 2'b11);
    step(2'b01, 64'h601, 64'h0, 2'b00, 2'b11);
    idle(1, 2'b11);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle(1, 2'b00);
      if (k == 0) begin
        reset = 1'b0;
        checkOutput("post-reset overflow", 64'(overflow), 64'h0);
      end
      checkOutput("post-reset out_valid", 64'(out_valid), 64'h0);
      checkOutput("post-reset in_almfull", 64'(in_almfull), (k < 3) ? 64'h3 : 64'h0);
    end
    checkOutput("final ch0 queue", 64'(exp_q0.size()), 64'h0);
    checkOutput("final ch1 queue", 64'(exp_q1.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
